// File: rtl/dataflow_rr_arbiter_if.sv
// Handshake bundle for dataflow_rr_arbiter: NUM_INPUTS packed source streams
// in, one tagged registered stream out.
interface dataflow_rr_arbiter_if #(
  parameter int unsigned NUM_INPUTS  = 2,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INDEX_WIDTH = 1
);
  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data;
  logic [NUM_INPUTS-1:0]            i_valid;
  logic [NUM_INPUTS-1:0]            i_ready;
  logic [DATA_WIDTH-1:0]            o_data;
  logic [INDEX_WIDTH-1:0]           o_index;
  logic                             o_valid;
  logic                             o_ready;

  // Arbiter side
  modport slave (
    input  i_data, i_valid, o_ready,
    output i_ready, o_data, o_index, o_valid
  );

  // Environment side: sources plus downstream sink
  modport master (
    output i_data, i_valid, o_ready,
    input  i_ready, o_data, o_index, o_valid
  );
endinterface

// File: rtl/dataflow_rr_arbiter.sv
// Round-robin merge of NUM_INPUTS valid/ready streams into one registered,
// source-tagged output stream (one-entry output stage, full throughput).
module dataflow_rr_arbiter #(
  parameter int unsigned NUM_INPUTS  = 2,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INDEX_WIDTH = 1
) (
  input  logic                clk,
  input  logic                reset,
  dataflow_rr_arbiter_if.slave bus
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [INDEX_WIDTH-1:0]  r_ptr;
  logic [INDEX_WIDTH-1:0]  w_ptr_next;
  logic [INDEX_WIDTH-1:0]  r_index;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [INDEX_WIDTH-1:0]  w_grant_idx;
  logic                    w_grant_found;
  logic [INDEX_WIDTH:0]    w_cand;
  logic                    w_can_accept;
  logic                    w_accept;
  logic [NUM_INPUTS-1:0]   w_ready;
  logic [DATA_WIDTH-1:0]   w_words [NUM_INPUTS];

  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_unpack
    assign w_words[k] = bus.i_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // First valid input at or after the pointer; the extra bit in w_cand lets
  // the wrap be done explicitly so non-power-of-two NUM_INPUTS works.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_cand        = '0;
    for (int unsigned off = 0; off < NUM_INPUTS; off++) begin
      w_cand = {1'b0, r_ptr} + (INDEX_WIDTH+1)'(off);
      if (w_cand >= (INDEX_WIDTH+1)'(NUM_INPUTS)) begin
        w_cand = w_cand - (INDEX_WIDTH+1)'(NUM_INPUTS);
      end
      if (!w_grant_found && bus.i_valid[w_cand[INDEX_WIDTH-1:0]]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = w_cand[INDEX_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    if (w_grant_idx == INDEX_WIDTH'(NUM_INPUTS - 1)) begin
      w_ptr_next = '0;
    end else begin
      w_ptr_next = w_grant_idx + INDEX_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept)                   w_state_next = ST_FULL;
      ST_FULL:  if (bus.o_ready && !w_accept)   w_state_next = ST_EMPTY;
      default:                                  w_state_next = ST_EMPTY;
    endcase
  end

  // Empty slot always takes a word; a full slot only when it drains this edge.
  always_comb begin
    w_can_accept = (r_state == ST_EMPTY) || bus.o_ready;
    w_accept     = w_grant_found && w_can_accept;
    w_ready      = '0;
    if (!reset && w_accept) begin
      w_ready[w_grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_index <= '0;
      r_ptr   <= '0;
    end else if (w_accept) begin
      r_data  <= w_words[w_grant_idx];
      r_index <= w_grant_idx;
      r_ptr   <= w_ptr_next;
    end
  end

  assign bus.i_ready = w_ready;
  assign bus.o_valid = (r_state == ST_FULL);
  assign bus.o_data  = r_data;
  assign bus.o_index = r_index;

endmodule

// File: tb/tb_dataflow_rr_arbiter.sv
// Directed-vector and scoreboard bench for dataflow_rr_arbiter (N=2 and N=3).
module tb_dataflow_rr_arbiter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dataflow_rr_arbiter_if #(.NUM_INPUTS(2), .DATA_WIDTH(32), .INDEX_WIDTH(1)) bus2 ();
  dataflow_rr_arbiter_if #(.NUM_INPUTS(3), .DATA_WIDTH(32), .INDEX_WIDTH(2)) bus3 ();

  dataflow_rr_arbiter #(.NUM_INPUTS(2), .DATA_WIDTH(32), .INDEX_WIDTH(1)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  dataflow_rr_arbiter #(.NUM_INPUTS(3), .DATA_WIDTH(32), .INDEX_WIDTH(2)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        ordy;
    logic [1:0]  exp_irdy;
    logic        exp_ov;
    logic        chk_data;
    logic [31:0] exp_od;
    logic        exp_idx;
  } vec_t;

  vec_t vt[18];

  // Scoreboard state for the random phase
  logic [31:0] q_data[$];
  int          q_idx[$];
  int unsigned seq[2];
  int          wait_cnt[2];
  logic        m_full;
  int          m_ptr;
  int          g;
  int          c;
  logic        g_found;
  logic        acc;
  logic        out_x;
  logic [1:0]  exp_rdy;
  int unsigned a3;
  int unsigned b3;
  int          g3;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // {valid, d0, d1, o_ready, exp i_ready, exp o_valid, chk data, exp o_data, exp o_index}
    vt[0]  = '{2'b10, 32'h0,   32'hA5A5_0001, 1'b1, 2'b10, 1'b1, 1'b1, 32'hA5A5_0001, 1'b1};
    vt[1]  = '{2'b10, 32'h0,   32'hA5A5_0002, 1'b1, 2'b10, 1'b1, 1'b1, 32'hA5A5_0002, 1'b1};
    vt[2]  = '{2'b10, 32'h0,   32'hA5A5_0003, 1'b1, 2'b10, 1'b1, 1'b1, 32'hA5A5_0003, 1'b1};
    vt[3]  = '{2'b10, 32'h0,   32'hA5A5_0004, 1'b1, 2'b10, 1'b1, 1'b1, 32'hA5A5_0004, 1'b1};
    vt[4]  = '{2'b10, 32'h0,   32'hA5A5_0005, 1'b1, 2'b10, 1'b1, 1'b1, 32'hA5A5_0005, 1'b1};
    vt[5]  = '{2'b00, 32'h0,   32'h0,         1'b1, 2'b00, 1'b0, 1'b0, 32'h0,         1'b0};
    vt[6]  = '{2'b11, 32'h100, 32'h200,       1'b1, 2'b01, 1'b1, 1'b1, 32'h100,       1'b0};
    vt[7]  = '{2'b11, 32'h101, 32'h200,       1'b1, 2'b10, 1'b1, 1'b1, 32'h200,       1'b1};
    vt[8]  = '{2'b11, 32'h101, 32'h201,       1'b1, 2'b01, 1'b1, 1'b1, 32'h101,       1'b0};
    vt[9]  = '{2'b11, 32'h102, 32'h201,       1'b1, 2'b10, 1'b1, 1'b1, 32'h201,       1'b1};
    vt[10] = '{2'b11, 32'h102, 32'h202,       1'b1, 2'b01, 1'b1, 1'b1, 32'h102,       1'b0};
    vt[11] = '{2'b11, 32'h103, 32'h202,       1'b0, 2'b00, 1'b1, 1'b1, 32'h102,       1'b0};
    vt[12] = '{2'b11, 32'h103, 32'h202,       1'b0, 2'b00, 1'b1, 1'b1, 32'h102,       1'b0};
    vt[13] = '{2'b11, 32'h103, 32'h202,       1'b0, 2'b00, 1'b1, 1'b1, 32'h102,       1'b0};
    vt[14] = '{2'b11, 32'h103, 32'h202,       1'b0, 2'b00, 1'b1, 1'b1, 32'h102,       1'b0};
    vt[15] = '{2'b11, 32'h103, 32'h202,       1'b1, 2'b10, 1'b1, 1'b1, 32'h202,       1'b1};
    vt[16] = '{2'b00, 32'h0,   32'h0,         1'b1, 2'b00, 1'b0, 1'b0, 32'h0,         1'b0};
    vt[17] = '{2'b01, 32'h104, 32'h0,         1'b0, 2'b01, 1'b1, 1'b1, 32'h104,       1'b0};

    reset         = 1'b1;
    bus2.i_valid  = 2'b11;
    bus2.i_data   = {32'h222, 32'h111};
    bus2.o_ready  = 1'b1;
    bus3.i_valid  = 3'b000;
    bus3.i_data   = '0;
    bus3.o_ready  = 1'b1;
    #2;
    chk("rst_ovalid", 64'(bus2.o_valid), 64'(0));
    chk("rst_odata",  64'(bus2.o_data),  64'(0));
    chk("rst_oindex", 64'(bus2.o_index), 64'(0));
    chk("rst_iready", 64'(bus2.i_ready), 64'(0));
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ovalid_clk", 64'(bus2.o_valid), 64'(0));
    bus2.i_valid = 2'b00;
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      bus2.i_valid = vt[i].valid;
      bus2.i_data  = {vt[i].d1, vt[i].d0};
      bus2.o_ready = vt[i].ordy;
      #2;
      chk($sformatf("v%0d_irdy", i), 64'(bus2.i_ready), 64'(vt[i].exp_irdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d_ovalid", i), 64'(bus2.o_valid), 64'(vt[i].exp_ov));
      if (vt[i].chk_data) begin
        chk($sformatf("v%0d_odata", i), 64'(bus2.o_data),  64'(vt[i].exp_od));
        chk($sformatf("v%0d_oidx", i),  64'(bus2.o_index), 64'(vt[i].exp_idx));
      end
    end

    // Asynchronous reset while holding word 0x104 with pointer at 1
    bus2.i_valid = 2'b11;
    bus2.i_data  = {32'h203, 32'h105};
    bus2.o_ready = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("arst_ovalid", 64'(bus2.o_valid), 64'(0));
    chk("arst_odata",  64'(bus2.o_data),  64'(0));
    chk("arst_oindex", 64'(bus2.o_index), 64'(0));
    chk("arst_iready", 64'(bus2.i_ready), 64'(0));
    @(posedge clk); #1;
    chk("arst_hold_ovalid", 64'(bus2.o_valid), 64'(0));
    reset = 1'b0;
    bus2.o_ready = 1'b1;
    #2;
    chk("post_rst_irdy", 64'(bus2.i_ready), 64'(2'b01));
    @(posedge clk); #1;
    chk("post_rst_odata", 64'(bus2.o_data),  64'(32'h105));
    chk("post_rst_oidx",  64'(bus2.o_index), 64'(0));
    chk("post_rst_ovld",  64'(bus2.o_valid), 64'(1));
    bus2.i_valid = 2'b00;
    @(posedge clk); #1;

    // N=3, only inputs 0 and 2 valid: grants alternate 0,2 with pointer wrap 2->0
    a3 = 0;
    b3 = 0;
    for (int n = 0; n < 6; n++) begin
      bus3.i_valid = 3'b101;
      bus3.i_data  = {32'h30 + b3, 32'h0, 32'h10 + a3};
      g3 = (n % 2 == 0) ? 0 : 2;
      #2;
      chk($sformatf("n3_%0d_irdy", n), 64'(bus3.i_ready), 64'((g3 == 0) ? 3'b001 : 3'b100));
      @(posedge clk); #1;
      chk($sformatf("n3_%0d_ovld", n), 64'(bus3.o_valid), 64'(1));
      chk($sformatf("n3_%0d_oidx", n), 64'(bus3.o_index), 64'(g3));
      chk($sformatf("n3_%0d_odat", n), 64'(bus3.o_data),  64'((g3 == 0) ? 32'h10 + a3 : 32'h30 + b3));
      if (g3 == 0) a3++; else b3++;
    end

    // Withdrawn valid: grant moves on to the next valid input
    bus3.i_valid = 3'b001;
    bus3.i_data  = {32'h3F, 32'h2F, 32'h1F};
    #1;
    chk("n3_wd_irdy0", 64'(bus3.i_ready), 64'(3'b001));
    bus3.i_valid = 3'b110;
    #1;
    chk("n3_wd_irdy1", 64'(bus3.i_ready), 64'(3'b010));
    @(posedge clk); #1;
    chk("n3_wd_oidx", 64'(bus3.o_index), 64'(1));
    chk("n3_wd_odat", 64'(bus3.o_data),  64'(32'h2F));
    bus3.i_valid = 3'b000;

    // Random valid/stall traffic on N=2 against a scoreboard
    #1 reset = 1'b1;
    bus2.i_valid = 2'b00;
    bus2.o_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_full = 1'b0;
    m_ptr  = 0;
    seq[0] = 0; seq[1] = 0;
    wait_cnt[0] = 0; wait_cnt[1] = 0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        if (!bus2.i_valid[k] && $urandom_range(0, 3) != 0) begin
          bus2.i_valid[k] = 1'b1;
          bus2.i_data[k*32 +: 32] = {8'(k), 24'(seq[k])};
        end
      end
      bus2.o_ready = ($urandom_range(0, 3) != 0);
      #2;
      g_found = 1'b0;
      g = 0;
      for (int off = 0; off < 2; off++) begin
        c = (m_ptr + off) % 2;
        if (!g_found && bus2.i_valid[c]) begin
          g_found = 1'b1;
          g = c;
        end
      end
      acc = g_found && (!m_full || bus2.o_ready);
      exp_rdy = acc ? ((g == 0) ? 2'b01 : 2'b10) : 2'b00;
      chk("rnd_irdy", 64'(bus2.i_ready), 64'(exp_rdy));
      chk("rnd_ovld", 64'(bus2.o_valid), 64'(m_full));
      if (m_full) begin
        chk("rnd_odata", 64'(bus2.o_data),  64'(q_data[0]));
        chk("rnd_oidx",  64'(bus2.o_index), 64'(q_idx[0]));
      end
      out_x = m_full && bus2.o_ready;
      @(posedge clk); #1;
      if (out_x) begin
        void'(q_data.pop_front());
        void'(q_idx.pop_front());
      end
      if (acc) begin
        q_data.push_back({8'(g), 24'(seq[g])});
        q_idx.push_back(g);
        seq[g]++;
        bus2.i_valid[g] = 1'b0;
        wait_cnt[g] = 0;
        if (bus2.i_valid[1-g]) begin
          wait_cnt[1-g]++;
          chk("rnd_starve", 64'(wait_cnt[1-g] > 1), 64'(0));
        end
        m_ptr = (g == 1) ? 0 : g + 1;
      end
      m_full = acc || (m_full && !bus2.o_ready);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
